// File: rtl/hls_fp17_to_fp16_pkg.sv
// Shared widths, exponent thresholds and class encoding for the fp17 -> fp16 converter.
// The subnormal class is only produced when HLS_FP17_TO_FP16_DENORM_EN is defined.
package hls_fp17_to_fp16_pkg;

    localparam int FP17_EXP_W   = 6;
    localparam int FP16_EXP_W   = 5;
    localparam int MANT_W       = 10;
    localparam int FP17_W       = 1 + FP17_EXP_W + MANT_W;
    localparam int FP16_W       = 1 + FP16_EXP_W + MANT_W;

    localparam int FP17_BIAS    = 31;
    localparam int FP16_BIAS    = 15;
    localparam int EXP_NORM_MIN = 17;
    localparam int EXP_OVF_MIN  = 47;
    localparam int EXP_SPECIAL  = 63;

    // Right shifts at or beyond this leave nothing that can round up to 1.
    localparam int SUBN_ZERO_SH = MANT_W + 2;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        SUBN,
        INF,
        NAN
    } fp_class_t;

    typedef struct packed {
        fp_class_t              cls;
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [MANT_W-1:0]      mant;
    } s1_t;

    function automatic fp_class_t classify(input logic [FP17_EXP_W-1:0] e, input logic mant_nz);
        if (e == FP17_EXP_W'(EXP_SPECIAL)) return mant_nz ? NAN : INF;
        if (e == '0)                       return ZERO;
        if (e >= FP17_EXP_W'(EXP_OVF_MIN)) return INF;
        if (e >= FP17_EXP_W'(EXP_NORM_MIN)) return NORM;
`ifdef HLS_FP17_TO_FP16_DENORM_EN
        return SUBN;
`else
        return ZERO;
`endif
    endfunction

endpackage

// File: rtl/hls_fp17_to_fp16_denorm_rnd.sv
// Combinational subnormal shifter with round-to-nearest-even.
// Used only when HLS_FP17_TO_FP16_DENORM_EN is defined.
module hls_fp17_to_fp16_denorm_rnd
    import hls_fp17_to_fp16_pkg::*;
(
    input  logic [MANT_W:0] mant_full,
    input  logic [4:0]      sh,
    output logic [MANT_W:0] q_rnd
);

    logic [MANT_W:0] q;
    logic [MANT_W:0] guard_mask;
    logic [MANT_W:0] sticky_mask;
    logic            guard;
    logic            sticky;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        guard_mask  = {{MANT_W{1'b0}}, 1'b1} << (sh - 5'd1);
        sticky_mask = guard_mask - {{MANT_W{1'b0}}, 1'b1};
        q           = mant_full >> sh;
        guard       = |(mant_full & guard_mask);
        sticky      = |(mant_full & sticky_mask);
        q_rnd       = q + {{MANT_W{1'b0}}, guard & (sticky | q[0])};
        if (sh >= 5'(SUBN_ZERO_SH)) begin
            q_rnd = '0;
        end
    end

endmodule

// File: rtl/hls_fp17_to_fp16_core_pipe.sv
// Two-stage fp17 -> fp16 converter with valid/ready on both sides.
// Define HLS_FP17_TO_FP16_DENORM_EN for RNE subnormal results; otherwise they flush to zero.
module hls_fp17_to_fp16_core_pipe
    import hls_fp17_to_fp16_pkg::*;
(
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              chn_a_pvld,
    output logic              chn_a_prdy,
    input  logic [FP17_W-1:0] chn_a_pd,
    output logic              chn_o_pvld,
    input  logic              chn_o_prdy,
    output logic [FP16_W-1:0] chn_o_pd
);

    logic                  in_sign;
    logic [FP17_EXP_W-1:0] in_exp;
    logic [MANT_W-1:0]     in_mant;
    logic                  s1_vld;
    logic                  s1_acc;
    logic                  s2_acc;
    s1_t                   s1_d;
    s1_t                   s1_q;
    logic [FP16_W-1:0]     pd_d;

    assign {in_sign, in_exp, in_mant} = chn_a_pd;

    assign s2_acc     = !chn_o_pvld || chn_o_prdy;
    assign s1_acc     = !s1_vld || s2_acc;
    assign chn_a_prdy = s1_acc;

    always_comb begin
        s1_d      = '0;
        s1_d.cls  = classify(in_exp, |in_mant);
        s1_d.sign = in_sign;
        s1_d.exp  = FP16_EXP_W'(in_exp - FP17_EXP_W'(FP17_BIAS - FP16_BIAS));
        s1_d.mant = in_mant;
    end

    // NOTE: payload registers are reset too, so the output word reads zero out of reset.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (s1_acc) begin
            s1_vld <= chn_a_pvld;
            if (chn_a_pvld) begin
                s1_q <= s1_d;
            end
        end
    end

`ifdef HLS_FP17_TO_FP16_DENORM_EN
    logic [4:0]      s1_sh;
    logic [MANT_W:0] q_rnd;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_sh <= '0;
        end else if (s1_acc && chn_a_pvld) begin
            s1_sh <= 5'(FP17_EXP_W'(EXP_NORM_MIN) - in_exp);
        end
    end

    hls_fp17_to_fp16_denorm_rnd u_denorm_rnd (
        .mant_full ({1'b1, s1_q.mant}),
        .sh        (s1_sh),
        .q_rnd     (q_rnd)
    );
`endif

    always_comb begin
        pd_d = {s1_q.sign, {(FP16_W-1){1'b0}}};
        case (s1_q.cls)
            NORM: pd_d = {s1_q.sign, s1_q.exp, s1_q.mant};
            INF:  pd_d = {s1_q.sign, {FP16_EXP_W{1'b1}}, {MANT_W{1'b0}}};
            NAN:  pd_d = {s1_q.sign, {FP16_EXP_W{1'b1}}, 1'b1, s1_q.mant[MANT_W-2:0]};
`ifdef HLS_FP17_TO_FP16_DENORM_EN
            // A rounding carry into bit 10 lands in the exponent field as the minimum normal.
            SUBN: pd_d = {s1_q.sign, (FP16_W-1)'(q_rnd)};
`endif
            default: pd_d = {s1_q.sign, {(FP16_W-1){1'b0}}};
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            chn_o_pvld <= 1'b0;
            chn_o_pd   <= '0;
        end else if (s2_acc) begin
            chn_o_pvld <= s1_vld;
            if (s1_vld) begin
                chn_o_pd <= pd_d;
            end
        end
    end

endmodule
